fetch_ifid_unit: RTL and testbench

- Instruction-fetch front end that consumes the PC from the PC-update stage and reads instruction memory over a valid/ready request and response handshake.
- Loads the IF/ID pipeline register with the fetched instruction and PC+4.
- Returns the `pcwrite` enable to the PC stage, so the PC advances exactly once per instruction accepted into IF/ID or per redirect.
- Handles variable memory latency, hazard stalls from the decode-side hazard unit, and branch/jump flushes.

---
 rtl/fetch_ifid_unit.sv | 134 +++++++++++++
 tb/tb_fetch_ifid_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_unit.sv
// Instruction-fetch front end: single-outstanding imem handshake feeding the
// IF/ID register, with hazard hold, flush/discard handling and pcwrite feedback.
module fetch_ifid_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              hazard_stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              pcwrite,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              accept;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        req_valid  = 1'b0;
        req_addr   = req_addr_q;
        accept     = 1'b0;

        unique case (state_q)
            S_REQ: begin
                req_addr  = pc;
                // A redirect withdraws the request so the target is fetched next.
                req_valid = ~flush;
                if (req_valid && imem_req_ready) begin
                    req_addr_d = pc;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q || flush) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (!hazard_stall) begin
                        accept  = 1'b1;
                        instr_d = imem_rsp_data;
                        pc4_d   = req_addr_q + ADDR_W'(4);
                        valid_d = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        hold_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_REQ;
                end else if (!hazard_stall) begin
                    accept  = 1'b1;
                    instr_d = hold_q;
                    pc4_d   = req_addr_q + ADDR_W'(4);
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Flush beats any load; the bubble keeps the old PC+4.
        if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc4_d   = pc4_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            req_addr_q <= '0;
            hold_q     <= '0;
            discard_q  <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req_valid = req_valid & ~reset;
    assign imem_req_addr  = req_addr;
    assign pcwrite        = (accept | flush) & ~reset;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_fetch_ifid_unit.sv
// Bench for fetch_ifid_unit: directed scenarios plus a randomized run
// against a program-order scoreboard with a latency-randomized memory.
module tb_fetch_ifid_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        hazard_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pcwrite;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ifid_unit #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush),
        .hazard_stall(hazard_stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .pcwrite(pcwrite), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; hazard_stall = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0;
    endtask

    task automatic test_reset();
        reset = 1; pc = 0; idle();
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got=%0h want=0", imem_req_valid); end
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL rst_pcwrite got=%0h want=0", pcwrite); end
        n_cmp++; if (if_id_instr !== NOP) begin n_bad++; $display("FAIL rst_instr got=%h want=%h", if_id_instr, NOP); end
        n_cmp++; if (if_id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4 got=%h want=0", if_id_pc_plus4); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0h want=0", if_id_valid); end
        tick();
    endtask

    task automatic test_basic();
        reset = 0; pc = 32'h0; imem_req_ready = 1;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL basic_req_valid got=%0h want=1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL basic_req_addr got=%h want=0", imem_req_addr); end
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h2008_0005;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL basic_pcwrite got=%0h want=1", pcwrite); end
        tick();
        imem_rsp_valid = 0; pc = 32'h4;
        @(negedge clk);
        n_cmp++; if (if_id_instr !== 32'h2008_0005) begin n_bad++; $display("FAIL basic_instr got=%h want=20080005", if_id_instr); end
        n_cmp++; if (if_id_pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL basic_pc4 got=%h want=4", if_id_pc_plus4); end
        n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%0h want=1", if_id_valid); end
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL basic_pcwrite_once got=%0h want=0", pcwrite); end
        tick();
    endtask

    task automatic test_ready_low();
        pc = 32'h10; imem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rdy_req_valid[%0d] got=%0h want=1", i, imem_req_valid); end
            n_cmp++; if (imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL rdy_req_addr[%0d] got=%h want=10", i, imem_req_addr); end
            n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL rdy_pcwrite[%0d] got=%0h want=0", i, pcwrite); end
            tick();
        end
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h8C09_0010;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL rdy_pcwrite_rsp got=%0h want=1", pcwrite); end
        tick();
        imem_rsp_valid = 0; pc = 32'h14;
        @(negedge clk);
        n_cmp++; if (if_id_pc_plus4 !== 32'h14) begin n_bad++; $display("FAIL rdy_pc4 got=%h want=14", if_id_pc_plus4); end
        n_cmp++; if (if_id_instr !== 32'h8C09_0010) begin n_bad++; $display("FAIL rdy_instr got=%h want=8c090010", if_id_instr); end
    endtask

    task automatic test_hazard_hold();
        pc = 32'h20; imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hAC0A_0020; hazard_stall = 1;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL hz_pcwrite_rsp got=%0h want=0", pcwrite); end
        tick();
        imem_rsp_valid = 0;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL hz_pcwrite_hold got=%0h want=0", pcwrite); end
        n_cmp++; if (if_id_instr !== 32'h8C09_0010) begin n_bad++; $display("FAIL hz_instr_held got=%h want=8c090010", if_id_instr); end
        n_cmp++; if (if_id_pc_plus4 !== 32'h14) begin n_bad++; $display("FAIL hz_pc4_held got=%h want=14", if_id_pc_plus4); end
        tick();
        hazard_stall = 0;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL hz_pcwrite_release got=%0h want=1", pcwrite); end
        tick();
        pc = 32'h24;
        @(negedge clk);
        n_cmp++; if (if_id_instr !== 32'hAC0A_0020) begin n_bad++; $display("FAIL hz_instr got=%h want=ac0a0020", if_id_instr); end
        n_cmp++; if (if_id_pc_plus4 !== 32'h24) begin n_bad++; $display("FAIL hz_pc4 got=%h want=24", if_id_pc_plus4); end
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL hz_pcwrite_once got=%0h want=0", pcwrite); end
    endtask

    task automatic test_flush_wait();
        pc = 32'h30; imem_req_ready = 1;
        tick();
        imem_req_ready = 0; flush = 1;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL fw_pcwrite got=%0h want=1", pcwrite); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL fw_req_valid got=%0h want=0", imem_req_valid); end
        tick();
        flush = 0; pc = 32'h40; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL fw_valid got=%0h want=0", if_id_valid); end
        n_cmp++; if (if_id_instr !== NOP) begin n_bad++; $display("FAIL fw_instr got=%h want=%h", if_id_instr, NOP); end
        n_cmp++; if (if_id_pc_plus4 !== 32'h24) begin n_bad++; $display("FAIL fw_pc4 got=%h want=24", if_id_pc_plus4); end
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL fw_stale_pcwrite got=%0h want=0", pcwrite); end
        tick();
        imem_rsp_valid = 0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL fw_req_valid2 got=%0h want=1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h40) begin n_bad++; $display("FAIL fw_req_addr got=%h want=40", imem_req_addr); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL fw_stale_dropped got=%0h want=0", if_id_valid); end
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0800_0100;
        tick();
        imem_rsp_valid = 0; pc = 32'h44;
        @(negedge clk);
        n_cmp++; if (if_id_pc_plus4 !== 32'h44) begin n_bad++; $display("FAIL fw_pc4_new got=%h want=44", if_id_pc_plus4); end
        n_cmp++; if (if_id_instr !== 32'h0800_0100) begin n_bad++; $display("FAIL fw_instr_new got=%h want=08000100", if_id_instr); end
    endtask

    task automatic test_flush_coincident();
        pc = 32'h50; imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h1111_2222; flush = 1;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL fc_pcwrite got=%0h want=1", pcwrite); end
        tick();
        imem_rsp_valid = 0; flush = 0; pc = 32'h60;
        @(negedge clk);
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL fc_valid got=%0h want=0", if_id_valid); end
        n_cmp++; if (if_id_instr !== NOP) begin n_bad++; $display("FAIL fc_instr got=%h want=%h", if_id_instr, NOP); end
        n_cmp++; if (imem_req_addr !== 32'h60) begin n_bad++; $display("FAIL fc_req_addr got=%h want=60", imem_req_addr); end
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h3333_4444; hazard_stall = 1;
        tick();
        imem_rsp_valid = 0; flush = 1;
        @(negedge clk);
        n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL fh_pcwrite got=%0h want=1", pcwrite); end
        tick();
        flush = 0; hazard_stall = 0; pc = 32'h70;
        @(negedge clk);
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL fh_valid got=%0h want=0", if_id_valid); end
        n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL fh_no_reload got=%0h want=0", pcwrite); end
        n_cmp++; if (imem_req_addr !== 32'h70) begin n_bad++; $display("FAIL fh_req_addr got=%h want=70", imem_req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h5555_6666;
        tick();
        imem_rsp_valid = 0; pc = 32'hFFFF_FFFC; imem_req_ready = 1;
        tick();
        imem_req_ready = 0;
        #2 reset = 1;
        #1;
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%0h want=0", if_id_valid); end
        n_cmp++; if (if_id_instr !== NOP) begin n_bad++; $display("FAIL arst_instr got=%h want=%h", if_id_instr, NOP); end
        n_cmp++; if (if_id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL arst_pc4 got=%h want=0", if_id_pc_plus4); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL arst_req_valid got=%0h want=0", imem_req_valid); end
        tick(); tick();
        reset = 0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL arst_restart got=%0h want=1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL arst_addr got=%h want=fffffffc", imem_req_addr); end
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h7777_8888;
        tick();
        imem_rsp_valid = 0; pc = 32'h0;
        @(negedge clk);
        n_cmp++; if (if_id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got=%h want=0", if_id_pc_plus4); end
        n_cmp++; if (if_id_instr !== 32'h7777_8888) begin n_bad++; $display("FAIL wrap_instr got=%h want=77778888", if_id_instr); end
        n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got=%0h want=1", if_id_valid); end
    endtask

    task automatic test_random();
        logic [31:0] pc_m, m_instr, m_pc4, tgt, pend_addr;
        logic        m_valid, pend;
        int          cnt;
        reset = 1; idle(); pc = 0;
        tick();
        reset = 0;
        pc_m = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; pend = 0; cnt = 0; tgt = 0;
        for (int c = 0; c < 3000; c++) begin
            flush          = ($urandom_range(0, 11) == 0);
            tgt            = $urandom & 32'hFFFF_FFFC;
            hazard_stall   = ($urandom_range(0, 2) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_rsp_valid = pend && (cnt == 0);
            imem_rsp_data  = imem_rsp_valid ? memf(pend_addr) : $urandom;
            pc             = pc_m;
            @(negedge clk);
            if (imem_req_valid) begin
                n_cmp++; if (imem_req_addr !== pc_m) begin n_bad++; $display("FAIL rnd_req_addr c=%0d got=%h want=%h", c, imem_req_addr, pc_m); end
            end
            if (flush) begin
                n_cmp++; if (pcwrite !== 1'b1) begin n_bad++; $display("FAIL rnd_flush_pcwrite c=%0d got=%0h want=1", c, pcwrite); end
                n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush_req c=%0d got=%0h want=0", c, imem_req_valid); end
            end else if (hazard_stall) begin
                n_cmp++; if (pcwrite !== 1'b0) begin n_bad++; $display("FAIL rnd_stall_pcwrite c=%0d got=%0h want=0", c, pcwrite); end
            end
            if (flush) begin
                m_instr = NOP; m_valid = 0; pc_m = tgt;
            end else if (pcwrite) begin
                m_instr = memf(pc_m); m_pc4 = pc_m + 32'd4; m_valid = 1; pc_m = pc_m + 32'd4;
            end
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++; if (pend !== 1'b0) begin n_bad++; $display("FAIL rnd_outstanding c=%0d got=%0h want=0", c, pend); end
                pend = 1; pend_addr = imem_req_addr; cnt = $urandom_range(0, 3);
            end else if (imem_rsp_valid) begin
                pend = 0;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
            tick();
            n_cmp++; if (if_id_instr !== m_instr) begin n_bad++; $display("FAIL rnd_instr c=%0d got=%h want=%h", c, if_id_instr, m_instr); end
            n_cmp++; if (if_id_pc_plus4 !== m_pc4) begin n_bad++; $display("FAIL rnd_pc4 c=%0d got=%h want=%h", c, if_id_pc_plus4, m_pc4); end
            n_cmp++; if (if_id_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%0h want=%0h", c, if_id_valid, m_valid); end
        end
        idle();
    endtask

    initial begin
        reset = 1; pc = 0; idle();
        test_reset();
        test_basic();
        test_ready_low();
        test_hazard_hold();
        test_flush_wait();
        test_flush_coincident();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
